// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch (i*) and
// load/store (d*) requesters.
//   - Requests are granted in IDLE. A tie is resolved by strict alternation
//     against last_grant.
//   - The operation, address and store data are latched when granted.
//   - The latched access is held on the RAM until ram_ready, or until the
//     timeout counter expires.
//   - The granted requester's wait drops for the single DONE cycle.
// Ports:
//   CLK/nRST                        clock, async active-low reset
//   iREN/iaddr/iwait/iload          instruction read requester
//   dREN/dWEN/daddr/dstore/dwait/dload  data requester
//   ram_ren/ram_wen/ram_addr/ram_store/ram_load/ram_ready  RAM port
//   flt_clr/fault                   sticky timeout flag and its clear
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  input  logic              flt_clr,
  output logic              fault
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic              op_wr, op_wr_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] store_q, store_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] iload_nxt, dload_nxt;
  logic              fault_nxt;
  logic              i_req, d_req, pick;

  assign i_req = iREN;
  assign d_req = dREN | dWEN;
  // Data wins when it is the only requester, or on a tie when inst went last.
  assign pick  = (d_req && (!i_req || last_grant == INST)) ? DATA : INST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      grant      <= INST;
      last_grant <= INST;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
      cnt        <= '0;
      iload      <= '0;
      dload      <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      op_wr      <= op_wr_nxt;
      addr_q     <= addr_nxt;
      store_q    <= store_nxt;
      cnt        <= cnt_nxt;
      iload      <= iload_nxt;
      dload      <= dload_nxt;
      fault      <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    op_wr_nxt      = op_wr;
    addr_nxt       = addr_q;
    store_nxt      = store_q;
    cnt_nxt        = cnt;
    iload_nxt      = iload;
    dload_nxt      = dload;
    // A timeout in the same cycle overrides the clear below.
    fault_nxt      = flt_clr ? 1'b0 : fault;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_nxt      = pick;
          last_grant_nxt = pick;
          // dREN together with dWEN is treated as a write.
          op_wr_nxt      = (pick == DATA) && dWEN;
          addr_nxt       = (pick == DATA) ? daddr : iaddr;
          store_nxt      = dstore;
          cnt_nxt        = '0;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_ready) begin
          if (!op_wr) begin
            if (grant == DATA) dload_nxt = ram_load;
            else               iload_nxt = ram_load;
          end
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          if (grant == DATA) dload_nxt = '0;
          else               iload_nxt = '0;
          fault_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_ren   = (state == ACCESS) && !op_wr;
  assign ram_wen   = (state == ACCESS) &&  op_wr;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;

  assign iwait = i_req && !(state == DONE && grant == INST);
  assign dwait = d_req && !(state == DONE && grant == DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, built with TIMEOUT = 4. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready, flt_clr;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        iwait, dwait, ram_ren, ram_wen, fault;
  logic [31:0] iload, dload, ram_addr, ram_store;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .flt_clr(flt_clr), .fault(fault)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h44; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ram_load = '0; ram_ready = 1'b0; flt_clr = 1'b0;
    #12;
    compared++;
    if ({ram_ren, ram_wen, fault, dwait} !== 4'b0 || ram_addr !== 0 ||
        ram_store !== 0 || iload !== 0 || dload !== 0) begin
      mismatched++;
      $display("FAIL reset_outputs: ren=%b wen=%b flt=%b dwait=%b addr=%h store=%h iload=%h dload=%h, required all 0",
               ram_ren, ram_wen, fault, dwait, ram_addr, ram_store, iload, dload);
    end
    compared++;
    if (iwait !== 1'b1) begin
      mismatched++; $display("FAIL reset_iwait: got %b, required 1", iwait);
    end
    tick(); nRST = 1'b1;
    tick();
    compared++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h44) begin
      mismatched++;
      $display("FAIL reset_first_grant: ren=%b addr=%h, required ren=1 addr=00000044", ram_ren, ram_addr);
    end
    ram_ready = 1'b1; tick();
    iREN = 1'b0; ram_ready = 1'b0; tick();
  endtask

  task automatic test_inst_read();
    iREN = 1'b1; iaddr = 32'h40; ram_load = 32'h8C220004;
    tick(); tick();
    compared++;
    if (ram_ren !== 1'b1 || ram_addr !== 32'h40 || iwait !== 1'b1) begin
      mismatched++;
      $display("FAIL iread_access: ren=%b addr=%h iwait=%b, required 1/00000040/1", ram_ren, ram_addr, iwait);
    end
    ram_ready = 1'b1; tick();
    compared++;
    if (iwait !== 1'b0 || iload !== 32'h8C220004 || ram_ren !== 1'b0) begin
      mismatched++;
      $display("FAIL iread_done: iwait=%b iload=%h ren=%b, required 0/8c220004/0", iwait, iload, ram_ren);
    end
    ram_ready = 1'b0; tick();
    compared++;
    if (iwait !== 1'b1 || iload !== 32'h8C220004) begin
      mismatched++;
      $display("FAIL iread_one_pulse: iwait=%b iload=%h, required 1/8c220004", iwait, iload);
    end
    iREN = 1'b0; tick();
  endtask

  task automatic test_data_write();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ram_ready = 1'b1;
    ram_load = 32'h12345678;
    tick();
    compared++;
    if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h100 ||
        ram_store !== 32'hDEADBEEF || dwait !== 1'b1) begin
      mismatched++;
      $display("FAIL dwrite_access: wen=%b ren=%b addr=%h store=%h dwait=%b, required 1/0/00000100/deadbeef/1",
               ram_wen, ram_ren, ram_addr, ram_store, dwait);
    end
    tick();
    compared++;
    if (dwait !== 1'b0 || dload !== 32'h0 || ram_wen !== 1'b0) begin
      mismatched++;
      $display("FAIL dwrite_done: dwait=%b dload=%h wen=%b, required 0/00000000/0", dwait, dload, ram_wen);
    end
    ram_ready = 1'b0; tick();
    compared++;
    if (dwait !== 1'b1) begin
      mismatched++; $display("FAIL dwrite_one_pulse: dwait=%b, required 1", dwait);
    end
    dWEN = 1'b0; tick();
  endtask

  task automatic test_timeout();
    // Prime dload with a non-zero value so the timeout zeroing is visible.
    dREN = 1'b1; daddr = 32'h200; ram_ready = 1'b1; ram_load = 32'h55AA55AA;
    tick(); tick();
    dREN = 1'b0; ram_ready = 1'b0; tick();
    compared++;
    if (dload !== 32'h55AA55AA) begin
      mismatched++; $display("FAIL dread_prime: dload=%h, required 55aa55aa", dload);
    end
    dREN = 1'b1; ram_load = 32'hFFFFFFFF;
    tick(); tick(); tick(); tick();
    compared++;
    if (ram_ren !== 1'b1 || dwait !== 1'b1 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_4th_access: ren=%b dwait=%b fault=%b, required 1/1/0", ram_ren, dwait, fault);
    end
    tick();
    compared++;
    if (dwait !== 1'b0 || dload !== 32'h0 || fault !== 1'b1 || ram_ren !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_done: dwait=%b dload=%h fault=%b ren=%b, required 0/00000000/1/0",
               dwait, dload, fault, ram_ren);
    end
    dREN = 1'b0; tick(); tick();
    compared++;
    if (fault !== 1'b1) begin
      mismatched++; $display("FAIL fault_sticky: fault=%b, required 1", fault);
    end
    flt_clr = 1'b1; tick();
    compared++;
    if (fault !== 1'b0) begin
      mismatched++; $display("FAIL fault_clear: fault=%b, required 0", fault);
    end
    // Clear held through a second timeout: the timeout must win.
    dREN = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    compared++;
    if (fault !== 1'b1 || dwait !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_beats_clear: fault=%b dwait=%b, required 1/0", fault, dwait);
    end
    dREN = 1'b0; tick();
    compared++;
    if (fault !== 1'b0) begin
      mismatched++; $display("FAIL fault_clear_after: fault=%b, required 0", fault);
    end
    flt_clr = 1'b0; tick();
  endtask

  task automatic test_contention();
    logic exp_data;
    logic [31:0] exp_addr;
    nRST = 1'b0; #2; nRST = 1'b1;
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h100;
    ram_ready = 1'b1; ram_load = 32'hA5A5_0000;
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0);
      exp_addr = exp_data ? 32'h100 : 32'h40;
      tick();
      compared++;
      if (ram_ren !== 1'b1 || ram_addr !== exp_addr) begin
        mismatched++;
        $display("FAIL contention_grant%0d: ren=%b addr=%h, required 1/%h", k, ram_ren, ram_addr, exp_addr);
      end
      tick();
      compared++;
      if (dwait !== !exp_data || iwait !== exp_data) begin
        mismatched++;
        $display("FAIL contention_done%0d: iwait=%b dwait=%b, required %b/%b", k, iwait, dwait, exp_data, !exp_data);
      end
      tick();
      compared++;
      if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin
        mismatched++;
        $display("FAIL contention_gap%0d: ren=%b wen=%b, required 0/0", k, ram_ren, ram_wen);
      end
    end
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0; tick();
  endtask

  task automatic test_mid_reset();
    dREN = 1'b1; daddr = 32'h300;
    tick(); tick(); tick(); tick(); tick();
    dREN = 1'b0; tick();
    dREN = 1'b1; tick();
    compared++;
    if (ram_ren !== 1'b1 || fault !== 1'b1) begin
      mismatched++; $display("FAIL midreset_pre: ren=%b fault=%b, required 1/1", ram_ren, fault);
    end
    #2 nRST = 1'b0; #1;
    compared++;
    if (ram_ren !== 1'b0 || fault !== 1'b0 || dwait !== 1'b1 || ram_addr !== 0) begin
      mismatched++;
      $display("FAIL midreset_async: ren=%b fault=%b dwait=%b addr=%h, required 0/0/1/00000000",
               ram_ren, fault, dwait, ram_addr);
    end
    tick();
    dREN = 1'b0; nRST = 1'b1; tick();
    compared++;
    if (ram_ren !== 1'b0 || dwait !== 1'b0 || dload !== 0) begin
      mismatched++;
      $display("FAIL midreset_after: ren=%b dwait=%b dload=%h, required 0/0/00000000", ram_ren, dwait, dload);
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_timeout();
    test_contention();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester (i*) and the load/store requester (d*) of the MIPS datapath.
- Sits between the fetch/memory stages and the RAM.
- Serialises accesses through a grant FSM, latches address and data per access, and returns a one-cycle completion (wait low) to the granted requester.
- Detects RAM timeouts and reports them through a sticky fault flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- TIMEOUT, 16, maximum ACCESS cycles before abort (legal range ≥ 2).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall.
- iload  out  DATA_W  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- dwait  out  1  data stall.
- dload  out  DATA_W  data read data.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM access complete this cycle.
- flt_clr  in  1  clears the fault flag.
- fault  out  1  sticky timeout flag.

Behaviour:
- One clock CLK; nRST is asynchronous, active-low. All state is cleared immediately on nRST low.
- Reset values:
  - FSM = IDLE.
  - ram_ren = 0, ram_wen = 0, ram_addr = 0, ram_store = 0.
  - iload = 0, dload = 0, fault = 0.
  - last_grant = INST, so the first tie goes to data.
  - Timeout counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is pending, grant, latch the operation, address and store data, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration, in IDLE only:
  - If only one side requests, that side is granted.
  - If both request, grant the side not in last_grant (strict alternation). last_grant updates on each grant.
- dREN and dWEN both high is treated as a write.
- ACCESS:
  - ram_ren or ram_wen is driven from the latched operation, with ram_addr and ram_store from the latch.
  - Requester inputs are ignored once latched.
  - If ram_ready is high, capture ram_load into iload or dload (read only; the load register is unchanged on a write) and go to DONE.
  - Else if counter == TIMEOUT-1, load 0 into the granted load register, set fault, and go to DONE.
  - Else increment the counter.
- DONE:
  - RAM strobes are low.
  - The granted requester's wait is low for exactly this cycle.
  - The counter is cleared; go to IDLE.
- Wait outputs:
  - iwait = iREN AND NOT (state == DONE AND grant == INST).
  - dwait = (dREN OR dWEN) AND NOT (state == DONE AND grant == DATA).
  - Wait is never low while the corresponding request is high, except in DONE.
- Load registers hold their value between accesses.
- Latency:
  - Request visible in IDLE at cycle N → strobe at N+1.
  - ram_ready sampled high at cycle M ≥ N+1 → DONE at M+1, wait low.
  - Minimum 3 cycles from request to completion.
- Back-to-back accesses: DONE always returns to IDLE, giving one idle RAM cycle between accesses.
- Dropped requests: a request dropped after grant still completes on the RAM. The DONE pulse then produces no wait change, since the request is low.
- ram_ready in IDLE or DONE is ignored.
- Fault:
  - Set on timeout; cleared by flt_clr or reset.
  - If flt_clr and a new timeout occur in the same cycle, the timeout wins and fault stays 1.

Test Plan:
- Reset: hold nRST = 0 with iREN = 1 → all outputs 0, iwait = 1. Release; ram_ren = 1 with ram_addr = iaddr one cycle after the first IDLE cycle.
- Single instruction read:
  - Stimulus: iaddr = 0x0040, ram_ready high on the 2nd ACCESS cycle, ram_load = 0x8C220004.
  - Response: iload = 0x8C220004, and iwait low for exactly one cycle, 4 cycles after the request.
- Single data write:
  - Stimulus: dWEN = 1, daddr = 0x0100, dstore = 0xDEADBEEF, ram_ready high in the first ACCESS cycle.
  - Response: ram_wen = 1, ram_store = 0xDEADBEEF, dwait low one cycle. dload unchanged.
- Contention:
  - Stimulus: iREN and dREN held high across four accesses from reset.
  - Response: grant order DATA, INST, DATA, INST, with a one-cycle IDLE gap between accesses.
- Timeout:
  - Stimulus: TIMEOUT = 4, dREN = 1, ram_ready never asserted.
  - Response: after 4 ACCESS cycles, dload = 0, fault = 1, dwait low one cycle.
  - Follow-up: fault stays 1 until flt_clr, which clears it on the next edge.
- Mid-access reset: assert nRST = 0 during ACCESS → ram_ren drops immediately, FSM = IDLE, fault = 0, no completion pulse.
